// File: rtl/i2lbs_scan_scheduler_pkg.sv
// Shared types for the I2LBS scan scheduler: FSM states and detection records.
package i2lbs_sched_pkg;

  localparam int DW      = 12;
  localparam int NS      = 4;
  localparam int SCALE_W = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_SCALE = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT       = 3'd3,
    ST_ADVANCE    = 3'd4,
    ST_DONE       = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic [DW-1:0]      x;
    logic [DW-1:0]      y;
    logic [SCALE_W-1:0] scale;
  } det_rec_t;

endpackage

// File: rtl/i2lbs_scan_scheduler_det_fifo.sv
// First-word fall-through FIFO of detection records with a sticky drop flag.
module i2lbs_det_fifo
  import i2lbs_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     clr_ovf_i,
  input  logic     push_i,
  input  det_rec_t push_rec_i,
  input  logic     pop_i,
  output logic     empty_o,
  output det_rec_t head_o,
  output logic     overflow_o
);

  localparam int AW = $clog2(DEPTH);

  det_rec_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          full_s;
  logic          do_push_s;
  logic          do_pop_s;

  // A pop frees a slot in the same cycle, so a push at full still succeeds.
  always_comb begin
    full_s    = (count_q == (AW+1)'(DEPTH));
    do_pop_s  = pop_i && (count_q != '0);
    do_push_s = push_i && (!full_s || do_pop_s);
  end

  // Storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= push_rec_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (clr_ovf_i) begin
        overflow_q <= 1'b0;
      end else if (push_i && !do_push_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign empty_o    = (count_q == '0);
  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

endmodule

// File: rtl/i2lbs_scan_scheduler.sv
// Multi-scale sliding-window scan sequencer for the I2LBS classifier.
module i2lbs_scan_scheduler
  import i2lbs_sched_pkg::*;
#(
  parameter int DATA_WIDTH_12   = DW,
  parameter int NUM_SCALE       = NS,
  parameter int INTEGRAL_WIDTH  = 3,
  parameter int INTEGRAL_HEIGHT = 3,
  parameter int WINDOW_STEP     = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk_fpga,
  input  logic                               reset_fpga,
  input  logic                               i_start,
  input  logic                               i_abort,
  input  logic [NUM_SCALE*DATA_WIDTH_12-1:0] i_cfg_width,
  input  logic [NUM_SCALE*DATA_WIDTH_12-1:0] i_cfg_height,
  output logic                               o_busy,
  output logic                               o_inspect_req,
  input  logic                               i_inspect_ack,
  input  logic                               i_inspect_done,
  input  logic                               i_candidate,
  output logic [DATA_WIDTH_12-1:0]           o_win_x,
  output logic [DATA_WIDTH_12-1:0]           o_win_y,
  output logic [SCALE_W-1:0]                 o_scale_idx,
  output logic                               o_det_valid,
  output logic [DATA_WIDTH_12-1:0]           o_det_x,
  output logic [DATA_WIDTH_12-1:0]           o_det_y,
  output logic [SCALE_W-1:0]                 o_det_scale,
  input  logic                               i_det_ready,
  output logic                               o_frame_done,
  output logic                               o_overflow
);

  // Window bounds are compared one bit wider than the coordinates so they never wrap.
  localparam int XW = DATA_WIDTH_12 + 1;
  localparam logic [XW-1:0] STEP_E  = XW'(WINDOW_STEP);
  localparam logic [XW-1:0] WIN_W_E = XW'(INTEGRAL_WIDTH);
  localparam logic [XW-1:0] WIN_H_E = XW'(INTEGRAL_HEIGHT);

  sched_state_e             state_q, state_d;
  logic [DATA_WIDTH_12-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [SCALE_W-1:0]       scale_q, scale_d;
  logic                     req_q, req_d, busy_q, busy_d, fdone_q, fdone_d;
  logic [XW-1:0]            x_next_s, y_next_s;
  logic                     last_scale_s, push_s, clr_ovf_s, fifo_empty_s;
  det_rec_t                 push_rec_s, head_s;
  logic [DATA_WIDTH_12-1:0] cfg_w_s [NUM_SCALE];
  logic [DATA_WIDTH_12-1:0] cfg_h_s [NUM_SCALE];

  for (genvar g = 0; g < NUM_SCALE; g++) begin : g_cfg
    assign cfg_w_s[g] = i_cfg_width[g*DATA_WIDTH_12 +: DATA_WIDTH_12];
    assign cfg_h_s[g] = i_cfg_height[g*DATA_WIDTH_12 +: DATA_WIDTH_12];
  end

  // Next-state, coordinate stepping and FIFO push decisions; abort overrides all.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    scale_d      = scale_q;
    push_s       = 1'b0;
    clr_ovf_s    = 1'b0;
    x_next_s     = {1'b0, x_q} + STEP_E;
    y_next_s     = {1'b0, y_q} + STEP_E;
    last_scale_s = (scale_q == SCALE_W'(NUM_SCALE - 1));
    push_rec_s   = {x_q, y_q, scale_q};
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            clr_ovf_s = 1'b1;
            scale_d   = '0;
            state_d   = ST_LOAD_SCALE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD_SCALE: begin
          w_d = cfg_w_s[scale_q];
          h_d = cfg_h_s[scale_q];
          x_d = '0;
          y_d = '0;
          if (({1'b0, cfg_w_s[scale_q]} < WIN_W_E) || ({1'b0, cfg_h_s[scale_q]} < WIN_H_E)) begin
            if (last_scale_s) begin
              state_d = ST_DONE;
            end else begin
              scale_d = scale_q + SCALE_W'(1);
              state_d = ST_LOAD_SCALE;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_inspect_ack) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_WAIT: begin
          if (i_inspect_done) begin
            push_s  = i_candidate;
            state_d = ST_ADVANCE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_ADVANCE: begin
          if (x_next_s + WIN_W_E <= {1'b0, w_q}) begin
            x_d     = x_next_s[DATA_WIDTH_12-1:0];
            state_d = ST_ISSUE;
          end else begin
            x_d = '0;
            if (y_next_s + WIN_H_E <= {1'b0, h_q}) begin
              y_d     = y_next_s[DATA_WIDTH_12-1:0];
              state_d = ST_ISSUE;
            end else if (last_scale_s) begin
              state_d = ST_DONE;
            end else begin
              scale_d = scale_q + SCALE_W'(1);
              state_d = ST_LOAD_SCALE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    req_d   = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
    fdone_d = (state_d == ST_DONE);
  end

  // State, window position and registered status outputs.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      scale_q <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      scale_q <= scale_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
    end
  end

  i2lbs_det_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_det_fifo (
    .clk_i      (clk_fpga),
    .rst_ni     (reset_fpga),
    .clr_ovf_i  (clr_ovf_s),
    .push_i     (push_s),
    .push_rec_i (push_rec_s),
    .pop_i      (i_det_ready),
    .empty_o    (fifo_empty_s),
    .head_o     (head_s),
    .overflow_o (o_overflow)
  );

  assign o_busy        = busy_q;
  assign o_inspect_req = req_q;
  assign o_frame_done  = fdone_q;
  assign o_win_x       = x_q;
  assign o_win_y       = y_q;
  assign o_scale_idx   = scale_q;
  assign o_det_valid   = !fifo_empty_s;
  assign o_det_x       = head_s.x;
  assign o_det_y       = head_s.y;
  assign o_det_scale   = head_s.scale;

endmodule

// File: doc/i2lbs_scan_scheduler.md
Name: i2lbs_scan_scheduler

Overview:
- Sequences the I2LBS classifier datapath over a multi-scale sliding-window scan of one frame.
- For each pyramid scale, steps the window origin across the resized frame and issues one inspect request per window to the classifier, with a req/ack/done handshake.
- Collects candidate results into a small detection FIFO as (x, y, scale) records.
- Sits between the frame-level control (start/abort) and the I2LBS classifier/memory pair. It replaces ad-hoc per-window request logic.

Parameters:
- DATA_WIDTH_12, 12, coordinate and dimension width.
- NUM_SCALE, 4, number of pyramid scales scanned per frame.
- INTEGRAL_WIDTH, 3, window width in pixels.
- INTEGRAL_HEIGHT, 3, window height in pixels.
- WINDOW_STEP, 1, window origin step in x and y.
- FIFO_DEPTH, 4, detection FIFO entries (power of two, >=2).

Ports:
- clk_fpga  in  1  sole clock.
- reset_fpga  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse; begin frame scan; honoured only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE next cycle.
- i_cfg_width  in  NUM_SCALE*DATA_WIDTH_12  resized frame width per scale; scale k at bits [k*12 +: 12].
- i_cfg_height  in  NUM_SCALE*DATA_WIDTH_12  resized frame height per scale.
- o_busy  out  1  high from the cycle after accepted i_start until return to IDLE.
- o_inspect_req  out  1  window ready for classifier.
- i_inspect_ack  in  1  classifier accepted the window.
- i_inspect_done  in  1  classifier finished the window (pulse).
- i_candidate  in  1  result; valid with i_inspect_done.
- o_win_x  out  DATA_WIDTH_12  current window origin x.
- o_win_y  out  DATA_WIDTH_12  current window origin y.
- o_scale_idx  out  clog2(NUM_SCALE)  current scale.
- o_det_valid  out  1  FIFO non-empty (first-word fall-through).
- o_det_x, o_det_y  out  DATA_WIDTH_12  head record coordinates.
- o_det_scale  out  clog2(NUM_SCALE)  head record scale.
- i_det_ready  in  1  pop head when o_det_valid is high.
- o_frame_done  out  1  one-cycle pulse at end of scan.
- o_overflow  out  1  sticky; a detection was dropped.

Behaviour:
- Reset (reset_fpga=0, async):
  - State goes to IDLE.
  - All outputs 0; coordinates and scale 0.
  - FIFO emptied; o_overflow cleared.
- States: IDLE, LOAD_SCALE, ISSUE, WAIT, ADVANCE, DONE.
- IDLE: on i_start, clear o_overflow, scale=0, go to LOAD_SCALE. Any i_start outside IDLE is ignored.
- LOAD_SCALE:
  - Latch w/h for the current scale; x=0, y=0.
  - If w<INTEGRAL_WIDTH or h<INTEGRAL_HEIGHT, skip the scale: go to DONE if it is the last scale, else scale+1 and stay in LOAD_SCALE.
  - Otherwise go to ISSUE.
- ISSUE:
  - o_inspect_req=1; o_win_x/o_win_y/o_scale_idx held stable.
  - When i_inspect_ack=1 in the same cycle as req, go to WAIT; req drops the next cycle.
- WAIT:
  - On i_inspect_done: if i_candidate=1, push {x, y, scale}; then go to ADVANCE.
  - i_inspect_done arriving in the same cycle as the ack is ignored; done is sampled only in WAIT.
- ADVANCE (arithmetic in DATA_WIDTH_12+1 bits, no wrap):
  - x' = x+WINDOW_STEP. If x'+INTEGRAL_WIDTH <= w, then x=x' and go to ISSUE.
  - Else x=0, y' = y+WINDOW_STEP. If y'+INTEGRAL_HEIGHT <= h, then y=y' and go to ISSUE.
  - Else next scale via LOAD_SCALE, or DONE after scale NUM_SCALE-1.
- DONE: o_frame_done=1 for one cycle, then IDLE.
- Latency: i_start at cycle 0 → LOAD_SCALE at 1 → first o_inspect_req at cycle 2. Each window takes ack-wait + done-wait + 2 cycles minimum.
- i_abort has priority over every other transition. It drops req immediately (registered, next cycle). FIFO contents are kept; o_busy falls.
- FIFO:
  - Push on full: record dropped, o_overflow=1.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Pop when empty: no effect.
  - Count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- Config ports are sampled only in LOAD_SCALE; changes mid-scale have no effect until the next scale.

Decomposition:
- Package i2lbs_sched_pkg:
  - state enum.
  - det_rec_t struct {x, y, scale}.
  - SCALE_W = clog2(NUM_SCALE) helper constant.
- Sub-module i2lbs_det_fifo:
  - Parameterised FWFT FIFO of det_rec_t.
  - push/pop/full/empty/overflow.
  - Same clock and async active-low reset.

Test Plan:
- Reset with FIFO holding 2 records, reset_fpga=0 mid-WAIT → all outputs 0, o_det_valid=0, IDLE, o_busy=0.
- Scale 0 w=h=3, scales 1-3 w=0, ack/done immediate, candidate=1 → exactly one req at (0,0,0), one record (0,0,0), o_frame_done pulse, 3 scales skipped.
- Scale 0 w=h=4, step 1, candidate=0 → req order (0,0),(1,0),(0,1),(1,1), then frame_done; no records.
- Ack delayed 5 cycles on the 2nd window → o_inspect_req stays high and o_win_x=1 is stable for all 5 cycles; one acceptance only.
- i_det_ready=0, w=5 h=4 (6 windows), candidate=1 each → 4 records in push order, o_overflow=1. Next i_start clears o_overflow. Same-cycle push+pop at full → no overflow.
- i_start pulsed while busy, and i_abort during ISSUE → start ignored; abort gives IDLE next cycle, req=0, FIFO intact, no frame_done.
